// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W        = 4;
    localparam int ADD3_THRESHOLD = 5;
    localparam int DIGITS_DEFAULT = 8;
    localparam int WIDTH_DEFAULT  = 28;
    // One extra scratch digit catches values above the displayable range.
    localparam int SCRATCH_DIGITS = DIGITS_DEFAULT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] bin_i,
    output logic [DIGIT_W-1:0] bcd_o
);

    always_comb begin
        bcd_o = bin_i;
        if (bin_i >= DIGIT_W'(ADD3_THRESHOLD))
            bcd_o = bin_i + DIGIT_W'(3);
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle shift-add-3 binary-to-BCD converter; digits, blank mask and
// overflow are updated together on a single-cycle done pulse.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int DIGITS = SCRATCH_DIGITS - 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          binario,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]         blank,
    output logic                      overflow
);

    localparam int SCR_W = DIGIT_W * (DIGITS + 1);
    localparam int SR_W  = SCR_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIG_W = DIGIT_W * DIGITS;

    state_e             state_q;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, ovf_q;
    logic [DIG_W-1:0]   digits_q, dig_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic [SCR_W-1:0]   scr_adj;
    logic               lz_run;

    genvar g;
    generate
        for (g = 0; g < DIGITS + 1; g++) begin : g_add3
            bcd_add3 u_add3 (
                .bin_i (sr_q[WIDTH + g*DIGIT_W +: DIGIT_W]),
                .bcd_o (scr_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // The adjusted top scratch bit is shifted out; it is always 0 for WIDTH-bit inputs.
    assign sr_d  = SR_W'({scr_adj, sr_q[WIDTH-1:0]} << 1);
    assign dig_d = sr_q[WIDTH +: DIG_W];

    always_comb begin
        blank_d = '0;
        lz_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run & (dig_d[i*DIGIT_W +: DIGIT_W] == '0);
            blank_d[i] = lz_run;
        end
        blank_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= {{SCR_W{1'b0}}, binario};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    digits_q <= dig_d;
                    ovf_q    <= (sr_q[WIDTH + DIG_W +: DIGIT_W] != '0);
                    blank_q  <= blank_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = ovf_q;

endmodule
